// File: rtl/rlc_pkg.sv
// rlc_pkg: shared constants, FSM state codes and zigzag-to-raster table for the RLC decoder
package rlc_pkg;
  localparam int PAIR_W = 16;
  localparam int RUN_W = 5;
  localparam logic [RUN_W-1:0] ZRL_RUN = 5'd31;
  localparam logic [PAIR_W-1:0] EOB_CODE = 16'h0000;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DC    = 3'd3;
  localparam logic [2:0] S_PAIR  = 3'd4;
  localparam logic [2:0] S_ZERO  = 3'd5;
  localparam logic [2:0] S_LEVEL = 3'd6;
  localparam logic [2:0] S_FILL  = 3'd7;
  localparam logic [5:0] ZZ_TO_RASTER [64] = '{
    0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6, 7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};
endpackage

// File: rtl/rlc_pair_unpack.sv
// rlc_pair_unpack: slices a coefficient word into DC and pair[ptr] (run, level) and classifies EOB/ZRL
module rlc_pair_unpack
  import rlc_pkg::*;
#(
  parameter int N = 10,
  parameter int DW = 107,
  parameter int DCW = 11,
  parameter int PAIRS = 6
) (
  input  logic [DW-1:0]    word,
  input  logic [2:0]       ptr,
  output logic [DCW-1:0]   dc,
  output logic [RUN_W-1:0] run,
  output logic [N:0]       level,
  output logic             eob,
  output logic             zrl
);
  logic [PAIR_W-1:0] pair;
  always_comb begin
    pair = '0;
    for (int k = 0; k < PAIRS; k++) pair = ptr == 3'(k) ? word[k*PAIR_W +: PAIR_W] : pair;
  end
  assign dc = word[DW-1 -: DCW];
  assign run = pair[PAIR_W-1 -: RUN_W];
  assign level = pair[N:0];
  assign eob = pair == EOB_CODE;
  assign zrl = run == ZRL_RUN && level == '0;
endmodule

// File: rtl/rlc_decoder.sv
// rlc_decoder: expands run-length-coded SRAM words into 64 zigzag-ordered coefficients per block; ports: start/start_addr/nblocks job launch, sram_raddr/sram_ren/sram_rdata read port, coef_valid/coef_ready/coef_data/coef_idx/coef_pos stream, block_done/busy/done/err status
module rlc_decoder
  import rlc_pkg::*;
#(
  parameter int N = 10,
  parameter int AW = 10,
  parameter int DW = 107,
  parameter int DCW = 11,
  parameter int PAIRS = 6
) (
  input  logic          clk,
  input  logic          srst_n,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] nblocks,
  output logic [AW-1:0] sram_raddr,
  output logic          sram_ren,
  input  logic [DW-1:0] sram_rdata,
  output logic          coef_valid,
  input  logic          coef_ready,
  output logic [N:0]    coef_data,
  output logic [5:0]    coef_idx,
  output logic [5:0]    coef_pos,
  output logic          block_done,
  output logic          busy,
  output logic          done,
  output logic          err
);
  logic [2:0] state;
  logic [AW-1:0] addr, nblk, blk;
  logic [5:0] idx, cnt;
  logic [2:0] ptr;
  logic zrl_q, done_q, err_q;
  logic [DW-1:0] word;
  logic [DCW-1:0] dc;
  logic [RUN_W-1:0] run;
  logic [N:0] level;
  logic eob, zrl, hs, last_hs, last_blk;
  logic [6:0] reach;
  rlc_pair_unpack #(.N(N), .DW(DW), .DCW(DCW), .PAIRS(PAIRS)) u_unpack (
    .word(word), .ptr(ptr), .dc(dc), .run(run), .level(level), .eob(eob), .zrl(zrl)
  );
  assign coef_valid = state == S_DC || state == S_ZERO || state == S_LEVEL || state == S_FILL;
  assign hs = coef_valid && coef_ready;
  assign last_hs = hs && idx == 6'd63;
  assign last_blk = blk == nblk - 1'b1;
  // index of the last coefficient this pair touches (the level, or the 32nd ZRL zero)
  assign reach = {1'b0, idx} + {2'b0, run};
  assign coef_data = state == S_DC ? dc : state == S_LEVEL ? level : '0;
  assign coef_idx = idx;
  assign coef_pos = ZZ_TO_RASTER[idx];
  assign sram_ren = state == S_FETCH;
  assign sram_raddr = addr;
  assign block_done = last_hs;
  assign busy = state != S_IDLE;
  assign done = done_q || (last_hs && last_blk);
  assign err = err_q;
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state <= S_IDLE;
      addr <= '0;
      nblk <= '0;
      blk <= '0;
      idx <= '0;
      cnt <= '0;
      ptr <= '0;
      zrl_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      word <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          err_q <= 1'b0;
          addr <= start_addr;
          nblk <= nblocks;
          blk <= '0;
          idx <= '0;
          done_q <= nblocks == '0;
          state <= nblocks == '0 ? S_IDLE : S_FETCH;
        end
        S_FETCH: begin
          addr <= addr + 1'b1;
          state <= S_WAIT;
        end
        S_WAIT: begin
          word <= sram_rdata;
          ptr <= '0;
          state <= idx == '0 ? S_DC : S_PAIR;
        end
        S_DC: if (hs) state <= S_PAIR;
        S_PAIR: if (ptr == 3'(PAIRS)) state <= S_FETCH;
        else if (eob) state <= S_FILL;
        else if (reach > 7'd63) begin
          err_q <= 1'b1;
          state <= S_FILL;
        end else if (zrl) begin
          cnt <= 6'd32;
          zrl_q <= 1'b1;
          state <= S_ZERO;
        end else if (run == '0) state <= S_LEVEL;
        else begin
          cnt <= {1'b0, run};
          zrl_q <= 1'b0;
          state <= S_ZERO;
        end
        S_ZERO: if (hs) begin
          cnt <= cnt - 1'b1;
          if (cnt == 6'd1) begin
            state <= zrl_q ? S_PAIR : S_LEVEL;
            ptr <= zrl_q ? ptr + 1'b1 : ptr;
          end
        end
        S_LEVEL: if (hs) begin
          ptr <= ptr + 1'b1;
          state <= S_PAIR;
        end
        default: ;
      endcase
      if (hs) idx <= idx + 1'b1;
      if (last_hs) begin
        blk <= blk + 1'b1;
        state <= last_blk ? S_IDLE : S_FETCH;
      end
    end
  end
endmodule

// File: tb/tb_rlc_decoder.sv
// tb_rlc_decoder: directed self-checking bench for rlc_decoder with an SRAM model and a coefficient recorder
module tb_rlc_decoder;
  logic clk = 0, srst_n = 0, start = 0, coef_ready = 1;
  logic [9:0] start_addr = '0, nblocks = '0, sram_raddr;
  logic sram_ren, coef_valid, block_done, busy, done, err;
  logic [106:0] sram_rdata = '0;
  logic [10:0] coef_data;
  logic [5:0] coef_idx, coef_pos;
  logic [106:0] mem [1024];
  logic [10:0] q_data [$];
  logic [5:0] q_idx [$], q_pos [$];
  logic q_bd [$], q_dn [$];
  logic [9:0] q_addr [$];
  logic [10:0] eb [64];
  logic [3:0] bp = 4'b1001;
  localparam logic [15:0] EOB = 16'h0000;
  int n_cmp = 0, n_bad = 0, ndone = 0, nbd = 0;
  bit bp_en = 0;
  rlc_decoder dut (
    .clk(clk), .srst_n(srst_n), .start(start), .start_addr(start_addr), .nblocks(nblocks),
    .sram_raddr(sram_raddr), .sram_ren(sram_ren), .sram_rdata(sram_rdata),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
    .coef_idx(coef_idx), .coef_pos(coef_pos), .block_done(block_done),
    .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (sram_ren) sram_rdata <= mem[sram_raddr];
  always @(negedge clk) begin
    if (coef_valid && coef_ready) begin
      q_data.push_back(coef_data);
      q_idx.push_back(coef_idx);
      q_pos.push_back(coef_pos);
      q_bd.push_back(block_done);
      q_dn.push_back(done);
    end
    if (sram_ren) q_addr.push_back(sram_raddr);
    if (done) ndone++;
    if (block_done) nbd++;
  end
  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge clk);
      #1;
      coef_ready = bp_en ? bp[k%4] : 1'b1;
      k++;
    end
  end
  function automatic logic [15:0] pr(input logic [4:0] r, input logic [10:0] l);
    return {r, l};
  endfunction
  function automatic logic [106:0] wd(input logic [10:0] dc, input logic [15:0] p0, p1, p2, p3, p4, p5);
    return {dc, p5, p4, p3, p2, p1, p0};
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clear_q();
    q_data.delete(); q_idx.delete(); q_pos.delete(); q_bd.delete(); q_dn.delete(); q_addr.delete();
    ndone = 0;
    nbd = 0;
  endtask
  task automatic clear_eb();
    for (int i = 0; i < 64; i++) eb[i] = '0;
  endtask
  task automatic wait_done(input string tag);
    for (int c = 0; c < 3000 && ndone == 0; c++) @(negedge clk);
    check({tag, "_done_seen"}, ndone, 1);
    repeat (2) @(negedge clk);
  endtask
  task automatic run_job(input string tag, input logic [9:0] a, input logic [9:0] nb);
    clear_q();
    @(negedge clk);
    start = 1; start_addr = a; nblocks = nb;
    @(negedge clk);
    start = 0;
    wait_done(tag);
  endtask
  task automatic chk_block(input string tag, input int base);
    check({tag, "_count"}, q_data.size() >= base + 64, 1);
    if (q_data.size() >= base + 64)
      for (int i = 0; i < 64; i++) begin
        check({tag, "_data"}, q_data[base+i], eb[i]);
        check({tag, "_idx"}, q_idx[base+i], i);
      end
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[10] = wd(11'h05A, EOB, EOB, EOB, EOB, EOB, EOB);
    mem[12] = wd(11'h010, pr(5'd0, 11'd3), pr(5'd2, 11'h7FF), pr(5'd31, 11'd0), pr(5'd0, 11'd7), EOB, EOB);
    mem[20] = wd(11'h100, pr(5'd0, 11'd1), pr(5'd0, 11'd2), pr(5'd1, 11'd3), pr(5'd0, 11'd4), pr(5'd0, 11'd5), pr(5'd2, 11'd6));
    mem[21] = wd(11'h3FF, pr(5'd0, 11'd7), pr(5'd3, 11'h400), EOB, pr(5'd0, 11'd9), pr(5'd0, 11'd9), pr(5'd0, 11'd9));
    mem[30] = wd(11'h001, pr(5'd31, 11'd0), pr(5'd31, 11'd0), pr(5'd5, 11'd9), EOB, EOB, EOB);
    mem[31] = wd(11'h7F0, pr(5'd0, 11'h055), EOB, EOB, EOB, EOB, EOB);
    mem[1023] = wd(11'h0AA, EOB, EOB, EOB, EOB, EOB, EOB);
    mem[0] = wd(11'h0BB, EOB, EOB, EOB, EOB, EOB, EOB);
    repeat (3) @(negedge clk);
    check("rst_ren", sram_ren, 0);
    check("rst_raddr", sram_raddr, 0);
    check("rst_valid", coef_valid, 0);
    check("rst_data", coef_data, 0);
    check("rst_idx", coef_idx, 0);
    check("rst_flags", {block_done, done, busy, err}, 0);
    srst_n = 1;
    @(negedge clk);
    // DC-only block with fetch latency
    clear_q();
    start = 1; start_addr = 10'd10; nblocks = 10'd1;
    @(negedge clk);
    start = 0;
    check("t1_ren", sram_ren, 1);
    check("t1_raddr", sram_raddr, 10);
    check("t1_busy", busy, 1);
    check("t1_valid_fetch", coef_valid, 0);
    @(negedge clk);
    check("t1_valid_wait", coef_valid, 0);
    @(negedge clk);
    check("t1_valid_dc", coef_valid, 1);
    check("t1_dc_data", coef_data, 11'h05A);
    wait_done("t1");
    clear_eb();
    eb[0] = 11'h05A;
    chk_block("t1", 0);
    if (q_data.size() == 64) begin
      check("t1_bd63", q_bd[63], 1);
      check("t1_dn63", q_dn[63], 1);
      check("t1_bd62", q_bd[62], 0);
    end
    check("t1_nbd", nbd, 1);
    check("t1_busy_end", busy, 0);
    // runs, levels and ZRL
    run_job("t2", 10'd12, 10'd1);
    clear_eb();
    eb[0] = 11'h010; eb[1] = 11'd3; eb[4] = 11'h7FF; eb[37] = 11'd7;
    chk_block("t2", 0);
    if (q_pos.size() == 64) begin
      check("t2_pos2", q_pos[2], 6'o10);
      check("t2_pos5", q_pos[5], 6'd2);
      check("t2_pos63", q_pos[63], 6'd63);
    end
    check("t2_err", err, 0);
    // block spanning two words
    run_job("t3", 10'd20, 10'd1);
    clear_eb();
    eb[0] = 11'h100; eb[1] = 11'd1; eb[2] = 11'd2; eb[4] = 11'd3; eb[5] = 11'd4;
    eb[6] = 11'd5; eb[9] = 11'd6; eb[10] = 11'd7; eb[14] = 11'h400;
    chk_block("t3", 0);
    check("t3_nfetch", q_addr.size(), 2);
    if (q_addr.size() == 2) check("t3_addr1", q_addr[1], 21);
    // backpressure on the run/level block
    bp_en = 1;
    run_job("t4", 10'd12, 10'd1);
    bp_en = 0;
    clear_eb();
    eb[0] = 11'h010; eb[1] = 11'd3; eb[4] = 11'h7FF; eb[37] = 11'd7;
    check("t4_transfers", q_data.size(), 64);
    chk_block("t4", 0);
    // overflow then a clean second block
    run_job("t5", 10'd30, 10'd2);
    clear_eb();
    eb[0] = 11'h001;
    chk_block("t5a", 0);
    check("t5_err", err, 1);
    clear_eb();
    eb[0] = 11'h7F0; eb[1] = 11'h055;
    chk_block("t5b", 64);
    check("t5_nbd", nbd, 2);
    check("t5_nfetch", q_addr.size(), 2);
    if (q_addr.size() == 2) check("t5_addr1", q_addr[1], 31);
    // nblocks = 0
    clear_q();
    @(negedge clk);
    start = 1; start_addr = 10'd5; nblocks = 10'd0;
    @(negedge clk);
    start = 0;
    check("t6_done", done, 1);
    check("t6_ren", sram_ren, 0);
    check("t6_busy", busy, 0);
    check("t6_err_cleared", err, 0);
    @(negedge clk);
    check("t6_done_pulse", done, 0);
    check("t6_nfetch", q_addr.size(), 0);
    // address wrap
    run_job("t7", 10'd1023, 10'd2);
    check("t7_nfetch", q_addr.size(), 2);
    if (q_addr.size() == 2) begin
      check("t7_addr0", q_addr[0], 1023);
      check("t7_addr1", q_addr[1], 0);
    end
    check("t7_count", q_data.size(), 128);
    if (q_data.size() == 128) begin
      check("t7_dc0", q_data[0], 11'h0AA);
      check("t7_dc1", q_data[64], 11'h0BB);
    end
    // asynchronous reset mid-block
    clear_q();
    @(negedge clk);
    start = 1; start_addr = 10'd12; nblocks = 10'd1;
    @(negedge clk);
    start = 0;
    for (int c = 0; c < 50 && q_data.size() < 3; c++) @(negedge clk);
    check("t8_midblock", q_data.size() >= 3, 1);
    #2;
    srst_n = 0;
    #1;
    check("t8_valid", coef_valid, 0);
    check("t8_busy", busy, 0);
    check("t8_ren", sram_ren, 0);
    check("t8_raddr", sram_raddr, 0);
    check("t8_data", coef_data, 0);
    check("t8_idx", coef_idx, 0);
    check("t8_flags", {block_done, done, err}, 0);
    @(negedge clk);
    srst_n = 1;
    run_job("t9", 10'd10, 10'd1);
    clear_eb();
    eb[0] = 11'h05A;
    chk_block("t9", 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rlc_decoder.md
Name: rlc_decoder

Overview:
- Inverse of the quantizer + RLC encode path: reads run-length-coded 107-bit words from the coefficient SRAM and expands them back into 64 quantized coefficients per 8x8 block.
- Coefficients are emitted in zigzag order, one per cycle, under a valid/ready handshake.
- Feeds the dequantizer / IDCT path on the decode side.

Parameters:
- N, 10, coefficient MSB index; coefficients are N+1 bits, two's complement.
- AW, 10, SRAM address width.
- DW, 107, SRAM word width; fixed to DCW + PAIRS*16.
- DCW, 11, DC field width (equal to N+1).
- PAIRS, 6, (run, level) pairs per SRAM word.

Ports:
- clk  in  1  system clock
- srst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that launches a decode job; ignored while busy
- start_addr  in  AW  first SRAM word of the job
- nblocks  in  AW  number of blocks to decode; 0 means immediate done
- sram_raddr  out  AW  SRAM read address
- sram_ren  out  1  SRAM read enable; rdata is valid exactly 1 cycle later
- sram_rdata  in  DW  SRAM read data
- coef_valid  out  1  coef_data, coef_idx and coef_pos are valid
- coef_ready  in  1  downstream accepts the current coefficient
- coef_data  out  N+1  quantized coefficient
- coef_idx  out  6  zigzag index, 0..63
- coef_pos  out  6  raster position {row[2:0], col[2:0]} = ZZ_TO_RASTER[coef_idx]
- block_done  out  1  one-cycle pulse with the handshake of coefficient idx 63
- busy  out  1  a job is in progress
- done  out  1  one-cycle pulse when the last block of the job completes
- err  out  1  sticky overflow flag; cleared by start

Behaviour:
- Word format:
  - [106:96] = DC.
  - Pair k (k = 0..5) is at [16k+15 : 16k]: run = [16k+15 : 16k+11] (5b), level = [16k+10 : 16k] (11b).
  - Pair 0 is consumed first.
- Pair codes:
  - run=0, level=0: EOB. The rest of the block is zeros; the remaining pairs in that word are ignored.
  - run=31, level=0: ZRL, i.e. 32 zeros and no coefficient.
  - Otherwise: emit `run` zeros, then `level`.
- Block framing:
  - A block always starts at a fresh word; its DC field is emitted as idx 0.
  - The DC field of continuation words is ignored.
  - A block ends at EOB or when idx 63 has been emitted. If idx 63 is reached by a level, the next word starts a new block and any EOB in the current word is not required.
- Reset values: sram_raddr=0, sram_ren=0, coef_valid=0, coef_data=0, coef_idx=0, block_done=0, done=0, busy=0, err=0, FSM=IDLE.
- FSM states and transitions:
  - IDLE: start with nblocks≠0 -> FETCH, busy=1, addr=start_addr. start with nblocks=0 -> done pulse next cycle, stay IDLE.
  - FETCH: sram_ren=1 for one cycle at addr; addr++ -> WAIT.
  - WAIT: register sram_rdata into the word buffer, pair pointer=0 -> DC if at block start, else PAIR.
  - DC: present DC at idx 0; on handshake -> PAIR.
  - PAIR: decode pair[ptr].
    - Non-zero code: load zero counter = run -> ZERO, or -> LEVEL if run=0.
    - ZRL: counter = 32 -> ZERO.
    - EOB -> FILL.
    - ptr==PAIRS (word exhausted) -> FETCH.
  - ZERO: emit 0, decrement counter per handshake. At 0 -> LEVEL; for ZRL -> PAIR with ptr++.
  - LEVEL: emit level, ptr++ -> PAIR.
  - FILL: emit 0 per handshake until idx 63.
  - Any state, handshake at idx 63: block_done pulse, block counter++, idx resets to 0. If this is the last block -> done pulse, IDLE, busy=0; otherwise -> FETCH with block-start flag set.
- Handshake:
  - A transfer happens when coef_valid && coef_ready.
  - coef_valid/data/idx are held stable while ready is low.
  - Peak throughput is 1 coefficient/cycle. A word fetch costs 2 bubble cycles.
- Overflow: if a run would carry idx past 63, set err, emit zeros up to idx 63, close the block and discard the rest of the word.
- Address: sram_raddr wraps modulo 2^AW.
- start while busy is ignored.
- Asynchronous reset mid-job returns everything to reset values immediately; the partial block is lost.

Decomposition:
- Package rlc_pkg:
  - Constants: EOB code, ZRL run value 31, PAIR_W=16, RUN_W=5.
  - ZZ_TO_RASTER[64] lookup (shared with the encoder's zigzag order).
  - State enum.
- One natural sub-module, rlc_pair_unpack: combinational slicing of the word into DC and pair[ptr], plus EOB/ZRL classification.

Test Plan:
- DC-only block: word DC=0x05A, pair0=EOB, nblocks=1, ready=1 -> idx0=0x05A, idx1..63=0, block_done and done on the idx-63 transfer, 2-cycle fetch latency from start.
- Runs and levels:
  - Stimulus: pairs (0,3), (2,-1=0x7FF), (31,0) ZRL, (0,7), EOB.
  - Expected: idx1=3; idx2,3=0; idx4=0x7FF; idx5..36=0; idx37=7; rest 0. coef_pos for idx 2 is {1,0}.
- Multi-word block: 8 non-zero pairs spanning two words -> continuation word's DC is ignored, ptr restarts at 0, second word is read at start_addr+1.
- Backpressure: coef_ready toggles 1,0,0,1 -> data and idx held during stalls, no coefficient lost or duplicated, 64 transfers counted.
- Overflow: pair (31,0) twice, then (5,9) -> err=1, zeros to idx 63, block closes, next block decodes correctly from the next word.
- Edge cases: nblocks=0 gives done the next cycle with no sram_ren; start_addr=1023 with 2 blocks makes the address wrap to 0; asserting srst_n low mid-block gives all outputs 0 asynchronously.
